// File: rtl/mmio_timer_resp.sv
// rtl/mmio_timer_resp.sv - MMIO responder for the timer/compare register block.
// Free-running cycle and microsecond counters plus a compare register with irq and auto-reload.
module mmio_timer_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000E000,
    parameter int          CLK_PER_US = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mmioAddr,
    input  logic [4:0]  mmioOpm,
    input  logic [63:0] mmioOutData,
    output logic [63:0] mmioInData,
    output logic [1:0]  mmioOK,
    output logic        timerIrq
);
    localparam logic [1:0]  RESP_READY = 2'b00;
    localparam logic [1:0]  RESP_OK    = 2'b01;
    localparam logic [1:0]  RESP_HOLD  = 2'b10;
    localparam logic [1:0]  RESP_FAULT = 2'b11;
    localparam logic [15:0] PRESC_MAX  = 16'(CLK_PER_US - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DONE} state_t;
    state_t state, state_next;

    logic [7:0]  req_addr;
    logic [4:0]  req_opm;
    logic [63:0] req_data;
    logic [63:0] ctr, usec, cmp, period;
    logic [15:0] presc;
    logic        ctrl_en, ctrl_pend, ctrl_reload;

    logic [1:0]  ok_next;
    logic [63:0] rdata_next;
    logic        latch, commit;
    logic        sel, is_load, is_store, is_quad, hi_half;
    logic [4:0]  idx;
    logic [63:0] reg_val, load_val, wr_val;
    logic [31:0] half;
    logic        hit, ctrl_wr, en_next, pend_next;

    assign sel     = (mmioAddr[31:8] == BASE_ADDR[31:8]);
    assign idx     = req_addr[7:3];
    assign hi_half = req_addr[2];
    assign is_quad = (req_opm[2:0] == 3'b011);

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (req_opm[4:3])
            2'b01:   is_load  = (req_opm[2:0] == 3'b010) || (req_opm[2:0] == 3'b011) ||
                                (req_opm[2:0] == 3'b110);
            2'b10:   is_store = (req_opm[2:0] == 3'b010) || (req_opm[2:0] == 3'b011);
            default: ;
        endcase
    end

    always_comb begin
        reg_val = 64'd0;
        case (idx)
            5'd0:    reg_val = ctr;
            5'd1:    reg_val = usec;
            5'd2:    reg_val = cmp;
            5'd3:    reg_val = {61'd0, ctrl_reload, ctrl_pend, ctrl_en};
            5'd4:    reg_val = period;
            default: reg_val = 64'd0;
        endcase
        half = hi_half ? reg_val[63:32] : reg_val[31:0];
        // opm[2] distinguishes UL (zero-extend) from SL (sign-extend)
        if (is_quad)
            load_val = reg_val;
        else if (req_opm[2])
            load_val = {32'd0, half};
        else
            load_val = {{32{half[31]}}, half};
        if (is_quad)
            wr_val = req_data;
        else if (hi_half)
            wr_val = {req_data[31:0], reg_val[31:0]};
        else
            wr_val = {reg_val[63:32], req_data[31:0]};
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ok_next    = mmioOK;
        rdata_next = mmioInData;
        latch      = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                ok_next    = RESP_READY;
                rdata_next = 64'd0;
                if (mmioOpm != 5'd0 && sel) begin
                    latch      = 1'b1;
                    state_next = ST_HOLD;
                    ok_next    = RESP_HOLD;
                end
            end
            ST_HOLD: begin
                state_next = ST_DONE;
                ok_next    = (is_load || is_store) ? RESP_OK : RESP_FAULT;
                rdata_next = is_load ? load_val : 64'd0;
                commit     = is_store;
            end
            ST_DONE: begin
                if (mmioOpm == 5'd0) begin
                    state_next = ST_IDLE;
                    ok_next    = RESP_READY;
                    rdata_next = 64'd0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ok_next    = RESP_READY;
                rdata_next = 64'd0;
            end
        endcase
    end

    // CTRL bits live in the low half, so an upper-half L store leaves them alone
    assign ctrl_wr   = commit && (idx == 5'd3) && (is_quad || !hi_half);
    assign hit       = ctrl_en && (usec >= cmp);
    assign en_next   = ctrl_wr ? req_data[0] : ctrl_en;
    assign pend_next = hit | (ctrl_pend & ~(ctrl_wr & req_data[1]));

    always_ff @(posedge clock) begin
        if (reset) begin
            mmioOK      <= RESP_READY;
            mmioInData  <= 64'd0;
            timerIrq    <= 1'b0;
            req_addr    <= 8'd0;
            req_opm     <= 5'd0;
            req_data    <= 64'd0;
            ctr         <= 64'd0;
            usec        <= 64'd0;
            presc       <= 16'd0;
            cmp         <= 64'd0;
            period      <= 64'd0;
            ctrl_en     <= 1'b0;
            ctrl_pend   <= 1'b0;
            ctrl_reload <= 1'b0;
        end else begin
            mmioOK     <= ok_next;
            mmioInData <= rdata_next;
            if (latch) begin
                req_addr <= mmioAddr[7:0];
                req_opm  <= mmioOpm;
                req_data <= mmioOutData;
            end
            ctr <= ctr + 64'd1;
            if (presc == PRESC_MAX) begin
                presc <= 16'd0;
                usec  <= usec + 64'd1;
            end else begin
                presc <= presc + 16'd1;
            end
            // A bus write to CMP takes priority over the auto-reload
            if (commit && idx == 5'd2)
                cmp <= wr_val;
            else if (hit && ctrl_reload)
                cmp <= cmp + period;
            if (commit && idx == 5'd4)
                period <= wr_val;
            if (ctrl_wr)
                ctrl_reload <= req_data[2];
            ctrl_en   <= en_next;
            ctrl_pend <= pend_next;
            timerIrq  <= en_next & pend_next;
        end
    end
endmodule

// File: tb/tb_mmio_timer_resp.sv
// tb/tb_mmio_timer_resp.sv - Self-checking bench for mmio_timer_resp.
// Directed handshake/timer scenarios followed by randomized accesses against a behavioural model.
module tb_mmio_timer_resp;
    localparam logic [31:0] BASE = 32'hF000E000;
    localparam int          CPU  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mmioAddr = 32'd0;
    logic [4:0]  mmioOpm = 5'd0;
    logic [63:0] mmioOutData = 64'd0;
    logic [63:0] mmioInData;
    logic [1:0]  mmioOK;
    logic        timerIrq;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_ctr = 0, m_usec = 0, m_cmp = 0, m_period = 0, m_rdata = 0;
    int          m_presc = 0;
    logic        m_en = 0, m_pend = 0, m_reload = 0, m_fault = 0;
    logic        p_valid = 0;
    logic [31:0] p_addr = 0;
    logic [4:0]  p_opm = 0;
    logic [63:0] p_data = 0;
    logic [63:0] rd;

    mmio_timer_resp #(.BASE_ADDR(BASE), .CLK_PER_US(CPU)) dut (
        .clock(clock), .reset(reset), .mmioAddr(mmioAddr), .mmioOpm(mmioOpm),
        .mmioOutData(mmioOutData), .mmioInData(mmioInData), .mmioOK(mmioOK), .timerIrq(timerIrq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_reg(input logic [4:0] i);
        case (i)
            5'd0:    return m_ctr;
            5'd1:    return m_usec;
            5'd2:    return m_cmp;
            5'd3:    return {61'd0, m_reload, m_pend, m_en};
            5'd4:    return m_period;
            default: return 64'd0;
        endcase
    endfunction

    // One clock of the reference timer, including the access the bench has queued for this edge.
    task automatic model_step();
        logic        hit, ld, st, clr;
        logic [63:0] cur, wv, new_cmp;
        logic [31:0] hf;
        if (reset) begin
            m_ctr = 0; m_usec = 0; m_presc = 0; m_cmp = 0; m_period = 0;
            m_en = 0; m_pend = 0; m_reload = 0; p_valid = 0;
            return;
        end
        hit = m_en && (m_usec >= m_cmp);
        new_cmp = (hit && m_reload) ? m_cmp + m_period : m_cmp;
        clr = 1'b0;
        if (p_valid) begin
            p_valid = 1'b0;
            ld = (p_opm[4:3] == 2'b01) && (p_opm[2:0] == 3'b010 || p_opm[2:0] == 3'b011 ||
                                            p_opm[2:0] == 3'b110);
            st = (p_opm[4:3] == 2'b10) && (p_opm[2:0] == 3'b010 || p_opm[2:0] == 3'b011);
            m_fault = !(ld || st);
            cur = m_reg(p_addr[7:3]);
            hf = p_addr[2] ? cur[63:32] : cur[31:0];
            m_rdata = 64'd0;
            if (ld) begin
                if (p_opm[2:0] == 3'b011)      m_rdata = cur;
                else if (p_opm[2:0] == 3'b010) m_rdata = {{32{hf[31]}}, hf};
                else                           m_rdata = {32'd0, hf};
            end
            if (st) begin
                if (p_opm[2:0] == 3'b011) wv = p_data;
                else if (p_addr[2])       wv = {p_data[31:0], cur[31:0]};
                else                      wv = {cur[63:32], p_data[31:0]};
                case (p_addr[7:3])
                    5'd2: new_cmp = wv;
                    5'd4: m_period = wv;
                    5'd3: if (p_opm[2:0] == 3'b011 || !p_addr[2]) begin
                        m_en = p_data[0]; m_reload = p_data[2]; clr = p_data[1];
                    end
                    default: ;
                endcase
            end
        end
        m_pend = hit || (m_pend && !clr);
        m_cmp = new_cmp;
        m_ctr = m_ctr + 1;
        if (m_presc == CPU - 1) begin
            m_presc = 0;
            m_usec = m_usec + 1;
        end else begin
            m_presc = m_presc + 1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("irq", 64'(timerIrq), 64'(m_en & m_pend));
    endtask

    task automatic txn(input logic [31:0] a, input logic [4:0] o, input logic [63:0] d,
                       input int hold, output logic [63:0] r);
        logic [1:0] exp_ok;
        mmioAddr = a; mmioOpm = o; mmioOutData = d;
        tick();
        if (a[31:8] != BASE[31:8]) begin
            for (int i = 0; i <= hold; i++) begin
                chk("unsel_ok", 64'(mmioOK), 64'd0);
                chk("unsel_data", mmioInData, 64'd0);
                if (i < hold) tick();
            end
            mmioOpm = 5'd0;
            tick();
            r = 64'd0;
            return;
        end
        chk("hold_ok", 64'(mmioOK), 64'd2);
        p_valid = 1'b1; p_addr = a; p_opm = o; p_data = d;
        tick();
        r = mmioInData;
        exp_ok = m_fault ? 2'b11 : 2'b01;
        chk("resp_ok", 64'(mmioOK), 64'(exp_ok));
        chk("resp_data", mmioInData, m_rdata);
        for (int i = 0; i < hold; i++) begin
            mmioAddr = $urandom;
            mmioOpm = 5'($urandom_range(1, 31));
            mmioOutData = {$urandom, $urandom};
            tick();
            chk("done_ok", 64'(mmioOK), 64'(exp_ok));
            chk("done_data", mmioInData, r);
        end
        mmioOpm = 5'd0;
        tick();
        chk("release_ok", 64'(mmioOK), 64'd0);
        chk("release_data", mmioInData, 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ok", 64'(mmioOK), 64'd0);
        chk("rst_data", mmioInData, 64'd0);
        chk("rst_irq", 64'(timerIrq), 64'd0);
        reset = 1'b0;

        txn(BASE, 5'b01011, 64'd0, 0, rd);
        chk("ctr_first", rd, 64'd1);

        txn(BASE + 32'h10, 5'b10011, 64'h1234, 0, rd);
        txn(BASE + 32'h14, 5'b01110, 64'd0, 0, rd);
        chk("ul_hi", rd, 64'd0);
        txn(BASE + 32'h10, 5'b10011, 64'hFFFFFFFF_80000000, 0, rd);
        txn(BASE + 32'h10, 5'b01010, 64'd0, 0, rd);
        chk("sl_lo", rd, 64'hFFFFFFFF_80000000);
        txn(BASE + 32'h14, 5'b10010, 64'h5, 0, rd);
        txn(BASE + 32'h10, 5'b01011, 64'd0, 0, rd);
        chk("stl_hi", rd, 64'h00000005_80000000);

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        txn(BASE + 32'h10, 5'b10011, 64'd3, 0, rd);
        txn(BASE + 32'h20, 5'b10011, 64'd2, 0, rd);
        txn(BASE + 32'h18, 5'b10011, 64'b101, 0, rd);
        for (int i = 0; i < 200 && !timerIrq; i++) tick();
        chk("irq_rise1", 64'(timerIrq), 64'd1);
        txn(BASE + 32'h18, 5'b10011, 64'b111, 0, rd);
        chk("irq_drop", 64'(timerIrq), 64'd0);
        txn(BASE + 32'h10, 5'b01011, 64'd0, 0, rd);
        chk("cmp_reload1", rd, 64'd5);
        for (int i = 0; i < 200 && !timerIrq; i++) tick();
        chk("irq_rise2", 64'(timerIrq), 64'd1);
        txn(BASE + 32'h08, 5'b01011, 64'd0, 0, rd);
        chk("usec_rise2", rd, 64'd5);
        txn(BASE + 32'h10, 5'b01011, 64'd0, 0, rd);
        chk("cmp_reload2", rd, 64'd7);

        txn(BASE + 32'h18, 5'b10011, 64'b010, 0, rd);
        txn(BASE + 32'h10, 5'b10011, 64'd0, 0, rd);
        txn(BASE + 32'h18, 5'b10011, 64'b011, 0, rd);
        txn(BASE + 32'h18, 5'b10011, 64'b011, 0, rd);
        chk("clr_vs_hit_irq", 64'(timerIrq), 64'd1);
        txn(BASE + 32'h18, 5'b01011, 64'd0, 0, rd);
        chk("clr_vs_hit_ctrl", rd, 64'd3);

        txn(BASE + 32'h08, 5'b10000, 64'hFF, 3, rd);
        txn(32'hF000F000, 5'b01011, 64'd0, 3, rd);

        mmioAddr = BASE + 32'h10; mmioOpm = 5'b10011; mmioOutData = 64'hABCD;
        tick();
        chk("rst_hold_ok", 64'(mmioOK), 64'd2);
        reset = 1'b1; mmioOpm = 5'd0;
        tick();
        chk("rst_abort_ok", 64'(mmioOK), 64'd0);
        reset = 1'b0;
        txn(BASE + 32'h10, 5'b01011, 64'd0, 0, rd);
        chk("rst_abort_cmp", rd, 64'd0);

        txn(BASE + 32'h20, 5'b10011, 64'h01234567_89ABCDEF, 20, rd);
        txn(BASE + 32'h20, 5'b01011, 64'd0, 0, rd);
        chk("long_hold_once", rd, 64'h01234567_89ABCDEF);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [4:0]  o;
            case ($urandom_range(0, 6))
                0:       o = 5'b01010;
                1:       o = 5'b01011;
                2:       o = 5'b01110;
                3:       o = 5'b10010;
                4, 5:    o = 5'b10011;
                default: o = 5'($urandom_range(1, 31));
            endcase
            if ($urandom_range(0, 9) == 0)
                a = {24'h123456, 8'($urandom)};
            else
                a = {BASE[31:8], 5'($urandom_range(0, 6)), 3'($urandom)};
            txn(a, o, {$urandom, $urandom}, $urandom_range(0, 3), rd);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_timer_resp.md
# mmio_timer_resp

MMIO responder for the timer/compare register block at the far end of the L2 MMIO port. It accepts requests on the L2-side `mmioAddr`/`mmioOpm`/`mmioOutData` signals and returns `mmioInData`/`mmioOK` to the L2 router under the standard READY/HOLD/OK handshake. It holds a free-running cycle counter, a microsecond counter, and a compare register with interrupt and auto-reload.

## Interface

Parameters:
- `BASE_ADDR`, default 32'hF000E000: base of the 256-byte window; selection is `addr[31:8] == BASE_ADDR[31:8]`.
- `CLK_PER_US`, default 50: clocks per microsecond tick; legal range 1..65535.

Ports:
- `clock` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `mmioAddr` input 32: request address from L2.
- `mmioOpm` input 5: request opcode; 5'b00000 = READY/idle.
- `mmioOutData` input 64: write data from L2.
- `mmioInData` output 64: read data to L2; 0 when not responding.
- `mmioOK` output 2: 00 READY, 01 OK, 10 HOLD, 11 FAULT.
- `timerIrq` output 1: level interrupt, `CTRL.en & CTRL.pend`.

## Operation

- Opcode classes:
  - `opm[4:3]=01` is a load. `opm[2:0]` is 010 SL, 011 Q, 110 UL.
  - `opm[4:3]=10` is a store. `opm[2:0]` is 010 L, 011 Q.
  - Any other nonzero opm to a selected address (byte, word, tile, cache commands) responds FAULT.
- Registers are 64-bit and indexed by `addr[7:3]`:
  - 0x00 CTR: cycle counter, +1 every clock, wraps to 0. Read-only; writes ignored and OK'd.
  - 0x08 USEC: +1 when prescaler reaches `CLK_PER_US-1`; prescaler then returns to 0. Read-only.
  - 0x10 CMP: compare value, R/W.
  - 0x18 CTRL: bit0 `en`, bit1 `pend`, bit2 `reload`; bits 63:3 read 0. A write sets `en` and `reload` from the data. Writing 1 to bit1 clears `pend`; writing 0 leaves it.
  - 0x20 PERIOD: reload increment, R/W.
  - Index 0x28..0xF8: reads 0; writes ignored; response OK.
- 32-bit access: `addr[2]` selects the half. Store L writes only that half of the register.
  - Load SL returns the half sign-extended to 64.
  - Load UL returns the half zero-extended to 64.
  - Q ignores `addr[2:0]`.
- Compare: when `USEC >= CMP` (unsigned) and `en`, set `pend`. If `reload` is also set, `CMP <= CMP + PERIOD` (mod 2^64) in the same cycle.
- Simultaneous events in one cycle:
  - Compare hit and a CTRL write clearing `pend`: `pend` ends set.
  - Bus write to CMP and an auto-reload: the bus write wins.
- Handshake state machine:
  - IDLE: `mmioOK=READY`, `mmioInData=0`. A nonzero `mmioOpm` with a selected address latches addr/opm/data and goes to HOLD. A non-selected address leaves the block in IDLE with outputs 0 (outputs are OR-combined with other devices).
  - HOLD, exactly 1 cycle: `mmioOK=HOLD`. Decode the access; a store commits here exactly once. Go to DONE.
  - DONE: `mmioOK` = OK or FAULT and `mmioInData` = read value, both held stable. Stay in DONE while `mmioOpm != 0`, even if addr/opm change. When `mmioOpm == 0`, go to IDLE.
- Reset values:
  - Outputs: `mmioOK=00`, `mmioInData=0`, `timerIrq=0`.
  - Registers: CTR, USEC, prescaler, CMP, CTRL and PERIOD are all 0. State IDLE.
- Reset in HOLD or DONE aborts the transaction. A pending store not yet committed is dropped.

## Timing

- All outputs are registered.
- Latency: a request is first seen at edge N. `mmioOK=HOLD` is visible after N, and OK/FAULT with data after N+1.
- Release: READY follows one cycle after `mmioOpm` is seen as 0.
- Minimum transaction: 3 cycles plus 1 release cycle. Back-to-back requests need an intervening opm=0 cycle.
- A CTR read returns the value sampled at the HOLD edge.
- `timerIrq` asserts one cycle after the compare-hit edge.
- `CLK_PER_US=1`: USEC increments every clock.

## Test plan

- Reset, then Q load of 0x00 at BASE: OK seen 2 cycles after the request. Data equals cycles since reset ±0 at the HOLD edge. Opm→0, and READY follows 1 cycle later.
- Q store of 0x1234 to 0x10, then UL load of 0x14 → 0. SL load of 0x10 after storing 0xFFFFFFFF_80000000 to 0x10 → 0xFFFFFFFF_80000000. Store L 0x5 to 0x14 → CMP reads 0x00000005_80000000.
- `CLK_PER_US=4`, CMP=3, CTRL=0b101, PERIOD=2:
  - `timerIrq` rises when USEC reaches 3, and CMP becomes 5.
  - Write CTRL=0b111 → irq drops.
  - USEC reaching 5 raises it again.
- Byte store to BASE+0x08 → FAULT held until opm=0, with no register change. A load from 0xF000F000 → outputs stay READY/0.
- Reset asserted during HOLD of a store to CMP → CMP stays 0 and `mmioOK` is READY the next cycle.
- Opm held nonzero 20 cycles in DONE → OK is held throughout and the store is committed once. Concurrent CTRL write clearing pend at a compare-hit edge → pend=1.
